// File: rtl/i2c_write_master_pkg.sv
// Shared state encoding, phase constants and defaults for the I2C write master.
package i2c_write_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBit,
        StAckb,
        StStop,
        StDone
    } i2cState_t;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam int unsigned DefaultDiv = 68;
    localparam int unsigned NumBytes   = 3;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one-cycle pulse every DIV clocks while enabled.
module i2c_tick_gen
    import i2c_write_master_pkg::*;
#(
    parameter int unsigned DIV = DefaultDiv
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic en,
    output logic tick
);

    logic [15:0] count;

    assign tick = en && (count == 16'(DIV - 1));

    // Held at zero while disabled so the first tick lands DIV cycles after enable.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count <= 16'd0;
        end else if (!en || tick) begin
            count <= 16'd0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// Serialises one 24-bit {slave, sub-address, data} command as an I2C write frame.
module i2c_write_master
    import i2c_write_master_pkg::*;
#(
    parameter int unsigned DIV = DefaultDiv
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [23:0] I2C_DATA,
    input  logic        GO,
    output logic        END,
    output logic        ACK,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    i2cState_t   state;
    logic [1:0]  phase;
    logic [2:0]  bitCnt;
    logic [1:0]  byteCnt;
    logic [23:0] shifter;
    logic        nack;
    logic        sdaLow;
    logic        tick;
    logic        tickEn;

    assign tickEn   = (state != StIdle);
    assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

    i2c_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .iCLK(iCLK),
        .iRST(iRST),
        .en  (tickEn),
        .tick(tick)
    );

    // Outputs are loaded on the tick that enters each phase, so they are registered.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= StIdle;
            phase    <= P0;
            bitCnt   <= 3'd0;
            byteCnt  <= 2'd0;
            shifter  <= 24'd0;
            nack     <= 1'b0;
            sdaLow   <= 1'b0;
            I2C_SCLK <= 1'b1;
            END      <= 1'b0;
            ACK      <= 1'b0;
        end else begin
            END <= (state == StDone) && GO;
            unique case (state)
                StIdle: begin
                    if (GO) begin
                        shifter <= I2C_DATA;
                        nack    <= 1'b0;
                        ACK     <= 1'b0;
                        phase   <= P0;
                        state   <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            P0: sdaLow <= 1'b1;
                            P1: I2C_SCLK <= 1'b0;
                            P3: begin
                                state   <= StBit;
                                bitCnt  <= 3'd7;
                                byteCnt <= 2'd0;
                                sdaLow  <= ~shifter[23];
                            end
                            default: ;
                        endcase
                    end
                end
                StBit: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            P1: I2C_SCLK <= 1'b1;
                            P3: begin
                                I2C_SCLK <= 1'b0;
                                shifter  <= {shifter[22:0], 1'b0};
                                if (bitCnt == 3'd0) begin
                                    state  <= StAckb;
                                    sdaLow <= 1'b0;
                                end else begin
                                    bitCnt <= bitCnt - 3'd1;
                                    sdaLow <= ~shifter[22];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StAckb: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            P1: I2C_SCLK <= 1'b1;
                            P2: nack <= nack | I2C_SDAT;
                            P3: begin
                                I2C_SCLK <= 1'b0;
                                // A NACK never aborts; every byte is always sent.
                                if (byteCnt < 2'(NumBytes - 1)) begin
                                    byteCnt <= byteCnt + 2'd1;
                                    bitCnt  <= 3'd7;
                                    state   <= StBit;
                                    sdaLow  <= ~shifter[23];
                                end else begin
                                    state  <= StStop;
                                    sdaLow <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StStop: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            P0: I2C_SCLK <= 1'b1;
                            P1: sdaLow <= 1'b0;
                            P3: begin
                                state <= StDone;
                                ACK   <= nack;
                            end
                            default: ;
                        endcase
                    end
                end
                StDone: begin
                    if (!GO) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Self-checking bench for i2c_write_master: frame-level model plus bus decoder.
module tb_i2c_write_master;

    localparam int TbDiv = 68;
    localparam int Frame = 116 * TbDiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data1 = 24'd0;
    logic [23:0] data2 = 24'd0;
    logic        go1 = 1'b0;
    logic        go2 = 1'b0;
    logic        end1, ack1, scl1;
    logic        end2, ack2, scl2;
    logic        slv1Low = 1'b0;
    logic        slv2Low = 1'b0;
    logic [2:0]  nackPat1 = 3'b000;
    wire         sda1;
    wire         sda2;

    pullup (sda1);
    pullup (sda2);
    assign sda1 = slv1Low ? 1'b0 : 1'bz;
    assign sda2 = slv2Low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_write_master #(.DIV(TbDiv)) dut (
        .iCLK(clk), .iRST(rst), .I2C_DATA(data1), .GO(go1),
        .END(end1), .ACK(ack1), .I2C_SCLK(scl1), .I2C_SDAT(sda1)
    );

    i2c_write_master #(.DIV(2)) dut2 (
        .iCLK(clk), .iRST(rst), .I2C_DATA(data2), .GO(go2),
        .END(end2), .ACK(ack2), .I2C_SCLK(scl2), .I2C_SDAT(sda2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bus for cycle k of a frame: 29 symbols of 4 phases, DIV cycles each.
    function automatic void waveAt(input int k, input int div, input logic [23:0] d,
                                   input logic [2:0] nk, output logic scl, output logic sda,
                                   output logic slaveAck);
        int sym, ph, b, pos;
        sym = k / (4 * div);
        ph = (k / div) % 4;
        slaveAck = 1'b0;
        if (sym == 0) begin
            scl = (ph < 2);
            sda = (ph == 0);
        end else if (sym == 28) begin
            scl = (ph != 0);
            sda = (ph >= 2);
        end else if (sym < 28) begin
            b = (sym - 1) / 9;
            pos = (sym - 1) % 9;
            scl = (ph >= 2);
            if (pos == 8) begin
                slaveAck = !nk[b];
                sda = nk[b];
            end else begin
                sda = d[23 - 8 * b - pos];
            end
        end else begin
            scl = 1'b1;
            sda = 1'b1;
        end
    endfunction

    typedef enum {MIdle, MRun, MDone} mState_t;
    mState_t     mSt = MIdle;
    int          mK = 0;
    logic [23:0] mData = 24'd0;
    logic [2:0]  mNack = 3'b000;
    logic        expScl = 1'b1, expSda = 1'b1, expEnd = 1'b0, expAck = 1'b0, slvAck = 1'b0;

    initial begin : scoreboard
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mSt = MIdle;
                expEnd = 1'b0;
                expAck = 1'b0;
            end else begin
                expEnd = (mSt == MDone) && go1;
                case (mSt)
                    MIdle: if (go1) begin
                        mSt = MRun; mK = 0; mData = data1; mNack = nackPat1; expAck = 1'b0;
                    end
                    MRun: begin
                        mK++;
                        if (mK == Frame) begin
                            mSt = MDone;
                            expAck = |mNack;
                        end
                    end
                    default: if (!go1) mSt = MIdle;
                endcase
            end
            if (mSt == MRun) waveAt(mK, TbDiv, mData, mNack, expScl, expSda, slvAck);
            else begin
                expScl = 1'b1; expSda = 1'b1; slvAck = 1'b0;
            end
            slv1Low = slvAck;
            @(negedge clk);
            if (rst) begin
                chk("rst_scl", {31'd0, scl1}, 1); chk("rst_sda", {31'd0, sda1}, 1);
                chk("rst_end", {31'd0, end1}, 0); chk("rst_ack", {31'd0, ack1}, 0);
            end else begin
                chk("scl", {31'd0, scl1}, {31'd0, expScl}); chk("sda", {31'd0, sda1}, {31'd0, expSda});
                chk("end", {31'd0, end1}, {31'd0, expEnd}); chk("ack", {31'd0, ack1}, {31'd0, expAck});
            end
        end
    end

    // Bus decoder: each entry is {byte, ack bit} as seen on SCL rising edges.
    logic [8:0] monQ[$];
    int startCnt = 0;
    int stopCnt = 0;

    initial begin : monitor
        logic pScl, pSda;
        logic [8:0] sh;
        int nb;
        pScl = 1'b1; pSda = 1'b1; sh = 9'd0; nb = 0;
        forever begin
            @(negedge clk);
            if (pScl && scl1 && pSda && !sda1) begin
                startCnt++;
                nb = 0;
            end else if (pScl && scl1 && !pSda && sda1) begin
                stopCnt++;
            end else if (!pScl && scl1) begin
                sh = {sh[7:0], sda1};
                nb++;
                if (nb == 9) begin
                    monQ.push_back(sh);
                    nb = 0;
                end
            end
            pScl = scl1;
            pSda = sda1;
        end
    end

    task automatic waitEnd(input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (end1 === 1'b1) begin
                cyc = c - 1;
                break;
            end
        end
    endtask

    task automatic checkBytes(input string name, input logic [8:0] b0, input logic [8:0] b1,
                              input logic [8:0] b2);
        chk({name, "_nbytes"}, monQ.size(), 3);
        if (monQ.size() == 3) begin
            chk({name, "_byte0"}, {23'd0, monQ[0]}, {23'd0, b0});
            chk({name, "_byte1"}, {23'd0, monQ[1]}, {23'd0, b1});
            chk({name, "_byte2"}, {23'd0, monQ[2]}, {23'd0, b2});
        end
    endtask

    initial begin : main
        int cyc, s0, p0, runs, bad, viol, runLen, endAt;
        bit endSeen, inRun;
        logic es, ed, sa, pScl2, pSda2;

        repeat (3) @(negedge clk);
        chk("reset_scl", {31'd0, scl1}, 1); chk("reset_sda", {31'd0, sda1}, 1);
        chk("reset_end", {31'd0, end1}, 0); chk("reset_ack", {31'd0, ack1}, 0);
        @(posedge clk); #3 rst = 1'b0;

        // All bytes acknowledged.
        @(negedge clk);
        monQ.delete(); p0 = stopCnt; data1 = 24'h200227; nackPat1 = 3'b000; go1 = 1'b1;
        waitEnd(Frame + 50, cyc);
        chk("t1_end_latency", cyc, 7889);
        chk("t1_ack", {31'd0, ack1}, 0);
        checkBytes("t1", 9'h040, 9'h004, 9'h04E);
        chk("t1_stop", stopCnt - p0, 1);

        // GO held after END: no second frame.
        s0 = startCnt;
        repeat (200) @(negedge clk);
        chk("hold_end", {31'd0, end1}, 1);
        chk("hold_no_restart", startCnt - s0, 0);
        go1 = 1'b0;
        @(negedge clk);
        chk("drop_end", {31'd0, end1}, 0);

        // Second byte NACKed; frame still completes.
        @(negedge clk);
        monQ.delete(); p0 = stopCnt; data1 = 24'hc00253; nackPat1 = 3'b010; go1 = 1'b1;
        waitEnd(Frame + 50, cyc);
        chk("t2_end_latency", cyc, 7889);
        chk("t2_ack", {31'd0, ack1}, 1);
        checkBytes("t2", 9'h180, 9'h005, 9'h0A6);
        chk("t2_stop", stopCnt - p0, 1);
        go1 = 1'b0;

        // New request clears ACK; then GO drops mid-frame.
        repeat (2) @(negedge clk);
        monQ.delete(); p0 = stopCnt; data1 = 24'hc00300; nackPat1 = 3'b000; go1 = 1'b1;
        @(negedge clk);
        chk("t3_ack_cleared", {31'd0, ack1}, 0);
        repeat (3300) @(negedge clk);
        go1 = 1'b0;
        endSeen = 1'b0;
        for (int i = 0; i < Frame; i++) begin
            @(negedge clk);
            if (end1) endSeen = 1'b1;
        end
        chk("t4_no_end", {31'd0, endSeen}, 0);
        checkBytes("t4", 9'h180, 9'h006, 9'h000);
        chk("t4_stop", stopCnt - p0, 1);

        // Asynchronous reset while byte 1 drives SDA low.
        @(negedge clk);
        monQ.delete(); data1 = 24'h200227; go1 = 1'b1;
        repeat (2731) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_async_scl", {31'd0, scl1}, 1); chk("t5_async_sda", {31'd0, sda1}, 1);
        chk("t5_async_end", {31'd0, end1}, 0); chk("t5_async_ack", {31'd0, ack1}, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        monQ.delete(); p0 = stopCnt;
        @(negedge clk);
        waitEnd(Frame + 50, cyc);
        chk("t5_end_latency", cyc, 7889);
        checkBytes("t5", 9'h040, 9'h004, 9'h04E);
        chk("t5_stop", stopCnt - p0, 1);
        go1 = 1'b0;

        // DIV=2 instance: exact waveform, SCL high width and SDA stability.
        @(negedge clk);
        data2 = 24'h5aa5c3; go2 = 1'b1;
        pScl2 = scl2; pSda2 = sda2;
        runs = 0; bad = 0; viol = 0; runLen = 0; endAt = -1; inRun = 1'b0;
        for (int k = 0; k < 240; k++) begin
            @(posedge clk);
            #1;
            waveAt(k, 2, data2, 3'b000, es, ed, sa);
            slv2Low = sa;
            @(negedge clk);
            chk("div2_scl", {31'd0, scl2}, {31'd0, es});
            chk("div2_sda", {31'd0, sda2}, {31'd0, ed});
            if (end2 && endAt < 0) endAt = k;
            if (sda2 != pSda2 && scl2 && pScl2 && !(k < 8 || (k >= 224 && k < 232))) viol++;
            if (scl2 && !pScl2) begin
                inRun = 1'b1; runLen = 1;
            end else if (scl2 && inRun) begin
                runLen++;
            end else if (!scl2 && pScl2 && inRun) begin
                runs++;
                if (runLen != 4) bad++;
                inRun = 1'b0;
            end
            pScl2 = scl2; pSda2 = sda2;
        end
        chk("div2_clock_pulses", runs, 27);
        chk("div2_bad_high_width", bad, 0);
        chk("div2_sda_change_scl_high", viol, 0);
        chk("div2_end_at", endAt, 233);
        chk("div2_ack", {31'd0, ack2}, 0);
        go2 = 1'b0;

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
